// File: rtl/fetch_unit.sv
// Instruction-fetch front end for the single-issue RV32I core.
// Issues one fetch at a time to instruction memory and hands the fetched word
// and its PC to decode over valid/ready. Decode returns the control-flow
// result during the handshake cycle, and that result forms the next PC.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic [1:0]      nextpcsel_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            fetch_err_o,
    output logic [31:0]     instr_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr_pc;
    logic [31:0]     r_instr;
    logic [31:0]     r_count;
    logic            r_err;

    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_jalr_sum;

    assign w_jalr_sum = rs1_i + imm_i;

    // Next PC from decode's control-flow result; all sums wrap modulo 2^XLEN.
    always_comb begin
        w_next_pc = r_instr_pc + XLEN'(4);
        case (nextpcsel_i)
            2'b01:   if (branch_taken_i) w_next_pc = r_instr_pc + imm_i;
            2'b10:   w_next_pc = r_instr_pc + imm_i;
            2'b11:   w_next_pc = w_jalr_sum & ~XLEN'(1);
            default: w_next_pc = r_instr_pc + XLEN'(4);
        endcase
    end

    // Fetch FSM with the PC, instruction latch, error flag and counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    // rvalid without a grant is not ours and is ignored
                    if (imem_gnt_i) begin
                        if (imem_rvalid_i) begin
                            r_instr    <= imem_rdata_i;
                            r_instr_pc <= r_pc;
                            r_state    <= S_VALID;
                        end else begin
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        r_instr    <= imem_rdata_i;
                        r_instr_pc <= r_pc;
                        r_state    <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready_i) begin
                        r_count <= r_count + 32'd1;
                        r_pc    <= w_next_pc;
                        // a misaligned target is fatal until the next reset
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o    = (r_state == S_FETCH);
    assign instr_valid_o = (r_state == S_VALID);
    assign imem_addr_o   = r_pc;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign fetch_err_o   = r_err;
    assign instr_count_o = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// memory/decode behaviour, all checked against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [1:0]  nextpcsel_i = '0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] imm_i = '0;
    logic [31:0] rs1_i = '0;
    logic        fetch_err_o;
    logic [31:0] instr_count_o;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .nextpcsel_i(nextpcsel_i), .branch_taken_i(branch_taken_i),
        .imm_i(imm_i), .rs1_i(rs1_i),
        .fetch_err_o(fetch_err_o), .instr_count_o(instr_count_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    // transaction model: 0 = just out of reset, 1 = request pending,
    // 2 = granted, awaiting data, 3 = word held for decode, 4 = halted
    int          m_ph;
    logic [31:0] m_pc, m_ipc, m_ins, m_cnt;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] target(input logic [1:0] sel, input logic tk,
                                           input logic [31:0] im, input logic [31:0] r1,
                                           input logic [31:0] p);
        case (sel)
            2'b00:   return p + 32'd4;
            2'b01:   return tk ? p + im : p + 32'd4;
            2'b10:   return p + im;
            default: return (r1 + im) & 32'hFFFF_FFFE;
        endcase
    endfunction

    task automatic mreset();
        m_ph = 0; m_pc = RPC; m_ipc = '0; m_ins = '0; m_cnt = '0; m_err = 1'b0;
    endtask

    // called at a negedge; asserts reset, checks async clear, releases at next negedge
    task automatic do_reset(input logic rv_during);
        rst_ni = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = rv_during;
        imem_rdata_i = $urandom;
        instr_ready_i = 1'b0;
        #1;
        chk("rst_req",   imem_req_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_err",   fetch_err_o, 0);
        chk("rst_cnt",   instr_count_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_ipc",   instr_pc_o, 0);
        chk("rst_addr",  imem_addr_o, RPC);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        imem_rvalid_i = 1'b0;
        mreset();
    endtask

    // one clock: drive inputs, check outputs against the model, advance the model
    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic [1:0] sel, input logic tk,
                       input logic [31:0] im, input logic [31:0] r1);
        imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
        instr_ready_i = rdy; nextpcsel_i = sel; branch_taken_i = tk;
        imm_i = im; rs1_i = r1;
        chk("req",   imem_req_o, (m_ph == 1));
        chk("valid", instr_valid_o, (m_ph == 3));
        chk("addr",  imem_addr_o, m_pc);
        chk("instr", instr_o, m_ins);
        chk("ipc",   instr_pc_o, m_ipc);
        chk("err",   fetch_err_o, m_err);
        chk("cnt",   instr_count_o, m_cnt);
        @(posedge clk_i);
        case (m_ph)
            0: m_ph = 1;
            1: if (g) begin
                   if (rv) begin m_ins = rd; m_ipc = m_pc; m_ph = 3; end
                   else m_ph = 2;
               end
            2: if (rv) begin m_ins = rd; m_ipc = m_pc; m_ph = 3; end
            3: if (rdy) begin
                   m_cnt = m_cnt + 1;
                   m_pc = target(sel, tk, im, r1, m_ipc);
                   if (m_pc[1:0] != 2'b00) begin m_err = 1'b1; m_ph = 4; end
                   else m_ph = 1;
               end
            default: ;
        endcase
        @(negedge clk_i);
    endtask

    task automatic idle(input logic rv);
        cyc(1'b0, rv, $urandom, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // one complete fetch: grant after gdly cycles, data rdly cycles after grant,
    // decode stalls rdy_dly cycles, then the handshake with the given result
    task automatic xfer(input int gdly, input int rdly, input logic [31:0] data,
                        input int rdy_dly, input logic [1:0] sel, input logic tk,
                        input logic [31:0] im, input logic [31:0] r1);
        for (int i = 0; i < 4 && m_ph != 1; i++) idle(1'b0);
        for (int i = 0; i < gdly; i++)
            cyc(1'b0, 1'($urandom), $urandom, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        if (rdly == 0) begin
            cyc(1'b1, 1'b1, data, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        end else begin
            cyc(1'b1, 1'b0, $urandom, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            for (int i = 0; i < rdly - 1; i++) idle(1'b0);
            cyc(1'b0, 1'b1, data, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        end
        for (int i = 0; i < rdy_dly; i++)
            cyc(1'b0, 1'($urandom), $urandom, 1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom);
        cyc(1'b0, 1'b0, $urandom, 1'b1, sel, tk, im, r1);
    endtask

    initial begin
        logic        g, rv, rdy, tk;
        logic [1:0]  sel;
        logic [31:0] im, r1;
        mreset();
        @(negedge clk_i);

        // zero-wait memory, always ready: 0x100, 0x104, 0x108
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 0, 32'h0000_0013, 0, 2'b00, 1'b0, 32'h0, 32'h0);
            chk("seq_addr", imem_addr_o, RPC + 32'd4 * (i + 1));
        end
        chk("seq_cnt3", instr_count_o, 32'd3);

        // grant after 3 cycles, data 2 cycles after grant
        do_reset(1'b0);
        xfer(3, 2, 32'hDEAD_BEEF, 0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("slow_next", imem_addr_o, 32'h104);

        // decode stalls 5 cycles, then jal with imm -16 from 0x100
        do_reset(1'b0);
        xfer(0, 0, 32'h1234_5678, 5, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0);
        chk("jal_req", imem_req_o, 1);
        chk("jal_tgt", imem_addr_o, 32'h0000_00F0);

        // reach 0x200, branch taken / not taken
        xfer(0, 0, $urandom, 0, 2'b10, 1'b0, 32'h0000_0110, 32'h0);
        chk("to_200", imem_addr_o, 32'h200);
        xfer(0, 1, $urandom, 0, 2'b01, 1'b1, 32'h0000_0040, 32'h0);
        chk("br_taken", imem_addr_o, 32'h240);
        xfer(1, 0, $urandom, 0, 2'b10, 1'b0, 32'hFFFF_FFC0, 32'h0);
        chk("back_200", imem_addr_o, 32'h200);
        xfer(0, 0, $urandom, 2, 2'b01, 1'b0, 32'h0000_0040, 32'h0);
        chk("br_not", imem_addr_o, 32'h204);

        // address wrap-around at the top of memory
        xfer(0, 0, $urandom, 0, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("jalr_top", imem_addr_o, 32'hFFFF_FFFC);
        xfer(0, 0, $urandom, 0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("wrap_zero", imem_addr_o, 32'h0);

        // jalr clears bit 0 only; bit 1 set is a fatal misalignment
        xfer(0, 0, $urandom, 0, 2'b11, 1'b0, 32'h0, 32'h0000_1001);
        chk("jalr_1000", imem_addr_o, 32'h1000);
        chk("jalr_ok", fetch_err_o, 0);
        xfer(0, 0, $urandom, 0, 2'b11, 1'b0, 32'h0, 32'h0000_1003);
        chk("halt_err", fetch_err_o, 1);
        chk("halt_req", imem_req_o, 0);
        for (int i = 0; i < 4; i++)
            cyc(1'($urandom), 1'($urandom), $urandom, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);

        // reset while waiting for data, with rvalid arriving during reset
        do_reset(1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b0, $urandom, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        idle(1'b0);
        do_reset(1'b1);
        chk("wrst_cnt", instr_count_o, 0);
        idle(1'b1);
        chk("wrst_addr", imem_addr_o, RPC);
        xfer(0, 0, 32'hCAFE_0001, 0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("wrst_cnt1", instr_count_o, 1);

        // randomized memory latency, decode stalls and control flow
        for (int k = 0; k < 3000; k++) begin
            if (m_ph == 4 && ($urandom % 4) == 0) begin
                do_reset(1'($urandom));
            end else begin
                g   = ($urandom % 3) != 0;
                rv  = 1'($urandom);
                rdy = 1'($urandom);
                tk  = 1'($urandom);
                sel = 2'($urandom);
                im  = $urandom & 32'h0000_0FFC;
                if ($urandom % 2) im = -im;
                if (($urandom % 40) == 0) im[1] = 1'b1;
                r1  = $urandom & 32'hFFFF_FFFD;
                cyc(g, rv, $urandom, rdy, sel, tk, im, r1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end for the single-issue RV32I core.
- Issues one fetch at a time to instruction memory and presents the fetched word, with its PC, to decode over a valid/ready handshake.
- When decode accepts a word, it returns the nextPCsel/branch/immediate/rs1 result for that instruction in the same cycle. The block uses it to form the next PC.
- Sits between the instruction memory port and the opcode decode / control logic.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk_i  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request, held until granted.
- imem_addr_o  out  XLEN  fetch address, always equal to pc_q.
- imem_gnt_i  in  1  memory accepted the request this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- instr_valid_o  out  1  instr_o/instr_pc_o are valid.
- instr_ready_i  in  1  decode accepts the instruction.
- instr_o  out  32  fetched instruction.
- instr_pc_o  out  XLEN  PC of instr_o.
- nextpcsel_i  in  2  00 = seq, 01 = branch, 10 = jal, 11 = jalr. Sampled only on handshake.
- branch_taken_i  in  1  branch condition result. Sampled only on handshake.
- imm_i  in  XLEN  sign-extended immediate. Sampled only on handshake.
- rs1_i  in  XLEN  rs1 value for jalr. Sampled only on handshake.
- fetch_err_o  out  1  sticky misaligned-target error.
- instr_count_o  out  32  accepted-instruction counter.

Behaviour:
- Reset (async, rst_ni = 0):
  - state = IDLE, pc_q = RESET_PC.
  - instr_o = 0, instr_pc_o = 0, fetch_err_o = 0, instr_count_o = 0.
  - imem_req_o = 0, instr_valid_o = 0.
  - Reset mid-fetch abandons the outstanding request. Any rvalid arriving in IDLE is ignored.
- State machine:
  - IDLE -> FETCH on the first clock after reset release.
  - FETCH: imem_req_o = 1.
    - gnt = 1 and rvalid = 1 in the same cycle: latch rdata into instr_o and pc_q into instr_pc_o, go to VALID.
    - gnt = 1 only: go to WAIT.
    - otherwise: stay in FETCH; imem_addr_o stays stable.
  - WAIT: imem_req_o = 0. On rvalid, latch rdata/pc and go to VALID. Otherwise stay.
  - VALID: instr_valid_o = 1. instr_o and instr_pc_o are held stable until the handshake (valid & ready).
    - On handshake: instr_count_o += 1 (wraps 0xFFFF_FFFF -> 0), pc_q <= next_pc.
    - If next_pc[1:0] != 0: fetch_err_o <= 1 and go to HALT. Otherwise go to FETCH.
  - HALT: terminal until reset. No requests; instr_valid_o = 0; fetch_err_o = 1.
  - imem_rvalid_i in FETCH without gnt, or in VALID/HALT, is ignored.
- next_pc, with p = instr_pc_o:
  - 00: p + 4.
  - 01: p + imm_i if branch_taken_i, else p + 4.
  - 10: p + imm_i.
  - 11: (rs1_i + imm_i) & ~1.
  - All additions are modulo 2^XLEN; wrap-around is allowed.
- Latency:
  - Handshake in cycle N -> imem_req_o = 1 with the new address in cycle N+1.
  - Zero-wait memory (gnt and rvalid together) -> instr_valid_o in the cycle after the request. One instruction every 2 cycles at best.
- Only one request is ever outstanding; no prefetch.
- imem_req_o and instr_valid_o are decoded from state. All other outputs are registered.

Test Plan:
- Reset with RESET_PC = 0x100, zero-wait memory returning 0x00000013, instr_ready_i = 1 -> requests at 0x100, 0x104, 0x108 on alternating cycles; instr_count_o = 3 after the third handshake.
- gnt delayed 3 cycles, then rvalid 2 cycles after gnt -> imem_addr_o stable at 0x100 throughout; instr_valid_o rises the cycle after rvalid; instr_o = rdata.
- instr_ready_i low for 5 cycles while valid -> instr_o and instr_pc_o stay constant, no new request. Then ready = 1 with nextpcsel_i = 10, imm_i = 0xFFFFFFF0 at pc 0x100 -> next request at 0xF0.
- Branch at pc 0x200 with imm = 0x40: taken -> next fetch 0x240; not taken -> next fetch 0x204.
- jalr with rs1 = 0x1003, imm = 0 -> next fetch 0x1002; bit 1 set, so fetch_err_o = 1, HALT, no further imem_req_o. Separately, rs1 = 0x1001 -> fetch at 0x1000, no error.
- rst_ni asserted while in WAIT, rvalid arriving during reset -> ignored; after release the first request is at RESET_PC and instr_count_o = 0.
